// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: receiver FSM states, framing bit levels, legal prescales
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [5:0] PRESCALE_X8  = 6'd8;
  localparam logic [5:0] PRESCALE_X16 = 6'd16;
  localparam logic [5:0] PRESCALE_X32 = 6'd32;
endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit tick counter and mid-bit sampling for uart_rx
// UART_RX_MAJORITY_VOTE_EN selects 2-of-3 voting over the three middle ticks instead of the centre tick.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       run,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  output logic       sample_bit,
  output logic       sample_rdy,
  output logic       bit_done
);
  logic [5:0] edge_cnt_q, edge_cnt_d;
  logic [5:0] half;
  logic       in_window;

  assign half = {1'b0, prescale[5:1]};

  // edge_cnt_q holds the tick index of the clock edge that just happened
  always_comb begin
    edge_cnt_d = '0;
    if (run) edge_cnt_d = (edge_cnt_q == prescale - 6'd1) ? 6'd0 : edge_cnt_q + 6'd1;
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [2:0] taps_q, taps_d;
  assign in_window  = (edge_cnt_d >= half - 6'd1) && (edge_cnt_d <= half + 6'd1);
  assign taps_d     = (run && in_window) ? {taps_q[1:0], rx_in} : taps_q;
  assign sample_bit = (taps_q[2] & taps_q[1]) | (taps_q[2] & taps_q[0]) | (taps_q[1] & taps_q[0]);
`else
  logic taps_q, taps_d;
  assign in_window  = (edge_cnt_d == half);
  assign taps_d     = (run && in_window) ? rx_in : taps_q;
  assign sample_bit = taps_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      taps_q     <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      taps_q     <= taps_d;
    end
  end

  assign sample_rdy = run && (edge_cnt_q == half + 6'd1);
  assign bit_done   = run && (edge_cnt_q == prescale - 6'd1);
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver: frame FSM, shift register, parity and stop checks
// Optional build macro UART_RX_MAJORITY_VOTE_EN (handled in uart_rx_sampler).
module uart_rx
  import uart_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic [5:0]       Prescale,
  output logic [width-1:0] P_DATA,
  output logic             DATA_VALID,
  output logic             PAR_ERR,
  output logic             STP_ERR
);
  localparam int CW = $clog2(width + 3);

  uart_rx_state_e   state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [width-1:0] shift_q, shift_d, p_data_q, p_data_d;
  logic [5:0]       prescale_q, prescale_d;
  logic             par_en_q, par_en_d, par_typ_q, par_typ_d, par_bad_q, par_bad_d;
  logic             data_valid_q, data_valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
  logic             sample_bit, sample_rdy, bit_done;

  uart_rx_sampler u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .run        (state_q != IDLE),
    .rx_in      (RX_IN),
    .prescale   (prescale_q),
    .sample_bit (sample_bit),
    .sample_rdy (sample_rdy),
    .bit_done   (bit_done)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_bad_d    = par_bad_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    unique case (state_q)
      IDLE: if (RX_IN == START_BIT) begin
        state_d    = START;
        bit_cnt_d  = '0;
        par_bad_d  = 1'b0;
        prescale_d = Prescale;
        par_en_d   = PAR_EN;
        par_typ_d  = PAR_TYP;
      end
      START: begin
        if (sample_rdy && sample_bit != START_BIT) begin
          state_d = IDLE;
        end else if (bit_done) begin
          state_d   = DATA;
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (sample_rdy) shift_d = {sample_bit, shift_q[width-1:1]};
        if (bit_done) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(width)) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample_rdy) par_bad_d = sample_bit != ((^shift_q) ^ par_typ_q);
        if (bit_done) begin
          state_d   = STOP;
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      STOP: if (sample_rdy) begin
        // leave mid-bit so a back-to-back start bit is never missed
        state_d      = IDLE;
        bit_cnt_d    = '0;
        p_data_d     = shift_q;
        par_err_d    = par_bad_q;
        stp_err_d    = sample_bit != STOP_BIT;
        data_valid_d = !par_bad_q && sample_bit == STOP_BIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_bad_q    <= par_bad_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: line waveforms decoded by a frame-level reference model
module tb_uart_rx;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR;

  uart_rx #(.width(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       dv, pe, se;
  } ev_t;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  bit   wave[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin : mon
    ev_t e;
    if (DATA_VALID || PAR_ERR || STP_ERR) begin
      e.cyc = cyc; e.data = P_DATA; e.dv = DATA_VALID; e.pe = PAR_ERR; e.se = STP_ERR;
      obs_q.push_back(e);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit wv(input int i);
    return (i >= 0 && i < wave.size()) ? wave[i] : 1'b1;
  endfunction

  function automatic bit smp(input int i);
`ifdef UART_RX_MAJORITY_VOTE_EN
    int ones;
    ones = int'(wv(i - 1)) + int'(wv(i)) + int'(wv(i + 1));
    return ones >= 2;
`else
    return wv(i);
`endif
  endfunction

  function automatic int legal_p();
    case ($urandom_range(0, 2))
      0:       return 8;
      1:       return 16;
      default: return 32;
    endcase
  endfunction

  task automatic add_idle(input int n, input bit v);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endtask

  task automatic add_frame(input int p, input logic [7:0] d, input bit pe, input bit pt,
                           input bit par_flip, input bit stop_v, input bit spike);
    bit bits[$];
    bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) bits.push_back(d[b]);
    if (pe) bits.push_back((^d) ^ pt ^ par_flip);
    bits.push_back(stop_v);
    foreach (bits[b])
      for (int t = 0; t < p; t++)
        wave.push_back((spike && b >= 1 && b <= 8 && t == p / 2) ? !bits[b] : bits[b]);
  endtask

  // Frame-level decode of the line: sample mid-bit, check start/parity/stop, predict pulse edge.
  task automatic model(input int base, input int p, input bit pe, input bit pt);
    int i;
    i = 0;
    exp_q.delete();
    while (i < wave.size()) begin
      if (wv(i) == 1'b0) begin
        int k, n;
        logic [7:0] d;
        bit par_bad, sb;
        ev_t e;
        k = i;
        if (smp(k + p / 2)) begin
          i = k + p / 2 + 3;
        end else begin
          for (int b = 0; b < 8; b++) d[b] = smp(k + (b + 1) * p + p / 2);
          n = pe ? 10 : 9;
          par_bad = pe && (smp(k + 9 * p + p / 2) != ((^d) ^ pt));
          sb = smp(k + n * p + p / 2);
          e.cyc = base + k + n * p + p / 2 + 2;
          e.data = d; e.dv = !par_bad && sb; e.pe = par_bad; e.se = !sb;
          exp_q.push_back(e);
          i = k + n * p + p / 2 + 3;
        end
      end else begin
        i++;
      end
    end
  endtask

  task automatic run_wave(input string tag, input int p, input bit pe, input bit pt,
                          input int scr_until, output int base);
    @(negedge CLK);
    PAR_EN = pe; PAR_TYP = pt; Prescale = 6'(p);
    obs_q.delete();
    @(negedge CLK);
    base = cyc + 1;
    foreach (wave[i]) begin
      if (i > 0) @(negedge CLK);
      RX_IN = wave[i];
      if (i > 0 && i < scr_until) begin
        PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); Prescale = 6'(legal_p());
      end else begin
        PAR_EN = pe; PAR_TYP = pt; Prescale = 6'(p);
      end
    end
    @(negedge CLK);
    RX_IN = 1'b1;
    repeat (4) @(negedge CLK);
    model(base, p, pe, pt);
    chk({tag, ".count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, ".cycle"}, obs_q[i].cyc, exp_q[i].cyc);
      chk({tag, ".data"},  obs_q[i].data, exp_q[i].data);
      chk({tag, ".valid"}, obs_q[i].dv, exp_q[i].dv);
      chk({tag, ".par_err"}, obs_q[i].pe, exp_q[i].pe);
      chk({tag, ".stp_err"}, obs_q[i].se, exp_q[i].se);
    end
    if (exp_q.size() > 0) chk({tag, ".hold"}, P_DATA, exp_q[exp_q.size() - 1].data);
  endtask

  initial begin
    int base, p;
    bit pe;

    repeat (3) @(negedge CLK);
    chk("reset.p_data", P_DATA, 0);
    chk("reset.valid", DATA_VALID, 0);
    chk("reset.par_err", PAR_ERR, 0);
    chk("reset.stp_err", STP_ERR, 0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    wave.delete(); add_frame(8, 8'hA5, 0, 0, 0, 1, 0); add_idle(40, 1);
    run_wave("nopar_a5", 8, 0, 0, 0, base);
    chk("nopar_a5.latency", obs_q.size() > 0 ? obs_q[0].cyc - base : -1, 78);
    chk("nopar_a5.word", P_DATA, 8'hA5);

    wave.delete(); add_frame(16, 8'h3C, 1, 0, 0, 1, 0); add_idle(40, 1);
    run_wave("even_ok", 16, 1, 0, 0, base);
    chk("even_ok.latency", obs_q.size() > 0 ? obs_q[0].cyc - base : -1, 170);

    wave.delete(); add_frame(16, 8'h3C, 1, 0, 1, 1, 0); add_idle(40, 1);
    run_wave("even_bad", 16, 1, 0, 0, base);
    chk("even_bad.par_err", obs_q.size() > 0 ? obs_q[0].pe : 1'bx, 1'b1);

    wave.delete(); add_frame(8, 8'h01, 1, 1, 0, 0, 0); add_idle(40, 1);
    run_wave("stop_err", 8, 1, 1, 0, base);
    chk("stop_err.word", P_DATA, 8'h01);

    wave.delete(); add_idle(4, 0); add_idle(60, 1); add_frame(32, 8'hFF, 0, 0, 0, 1, 0); add_idle(40, 1);
    run_wave("glitch", 32, 0, 0, 0, base);
    chk("glitch.frames", obs_q.size(), 1);

    wave.delete(); add_frame(16, 8'h55, 0, 0, 0, 1, 1); add_idle(40, 1);
    run_wave("spike", 16, 0, 0, 0, base);
`ifdef UART_RX_MAJORITY_VOTE_EN
    chk("spike.word", P_DATA, 8'h55);
`else
    chk("spike.word", P_DATA, 8'hAA);
`endif

    wave.delete(); add_frame(8, 8'h12, 0, 0, 0, 1, 0); add_frame(8, 8'h34, 0, 0, 0, 1, 0); add_idle(40, 1);
    run_wave("b2b", 8, 0, 0, 0, base);
    chk("b2b.frames", obs_q.size(), 2);

    // Reset asserted mid-data: outputs must clear without waiting for a clock edge.
    wave.delete(); add_frame(16, 8'h5A, 0, 0, 0, 1, 0);
    @(negedge CLK); PAR_EN = 1'b0; Prescale = 6'd16;
    for (int i = 0; i < 16 * 4; i++) begin
      RX_IN = wave[i];
      @(negedge CLK);
    end
    #2 RST = 1'b0;
    #1;
    chk("midrst.p_data", P_DATA, 0);
    chk("midrst.valid", DATA_VALID, 0);
    chk("midrst.par_err", PAR_ERR, 0);
    chk("midrst.stp_err", STP_ERR, 0);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    wave.delete(); add_frame(8, 8'hC3, 0, 0, 0, 1, 0); add_idle(40, 1);
    run_wave("after_rst", 8, 0, 0, 0, base);

    for (int r = 0; r < 16; r++) begin
      p  = legal_p();
      pe = 1'($urandom);
      wave.delete();
      add_idle($urandom_range(0, 5), 1);
      add_frame(p, 8'($urandom), pe, 1'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0);
      add_idle(2 * p + 8, 1);
      run_wave($sformatf("rand%0d", r), p, pe, wave[0] ? 1'b0 : 1'b0, 0, base);
    end

    for (int r = 0; r < 6; r++) begin
      bit pt;
      p  = legal_p();
      pe = 1'($urandom);
      pt = 1'($urandom);
      wave.delete();
      add_frame(p, 8'($urandom), pe, pt, 0, 1, 0);
      add_idle(2 * p + 8, 1);
      run_wave($sformatf("latch%0d", r), p, pe, pt, (pe ? 10 : 9) * p, base);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
